// File: rtl/alu_shift_pkg.sv
// Shared definitions for the shift/rotate path: mode encodings used by the
// single-bit shifter and the sequencer state encoding.
package alu_shift_pkg;

    localparam logic [1:0] ROR = 2'b00;
    localparam logic [1:0] ROL = 2'b01;
    localparam logic [1:0] SHR = 2'b10;
    localparam logic [1:0] SHL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Mode bit 0 selects the direction: 0 = right, 1 = left.
    function automatic logic is_left(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/shift_step.sv
// Single-bit shift/rotate stage: applies one step of the selected mode and
// reports the bit that leaves the operand on that step.
module shift_step
    import alu_shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] x,
    input  logic [1:0]   mode,
    output logic [N-1:0] y,
    output logic         bit_out
);

    logic [N-1:0] right_fill;
    logic [N-1:0] left_fill;

    // Interior bits are the same for rotate and shift; only the end bit differs.
    genvar gi;
    generate
        for (gi = 0; gi < N - 1; gi++) begin : g_right
            assign right_fill[gi] = x[gi+1];
        end
        for (gi = 1; gi < N; gi++) begin : g_left
            assign left_fill[gi] = x[gi-1];
        end
    endgenerate

    always_comb begin
        y = x;
        case (mode)
            ROR: y = {x[0], right_fill[N-2:0]};
            ROL: y = {left_fill[N-1:1], x[N-1]};
            SHR: y = {1'b0, right_fill[N-2:0]};
            SHL: y = {left_fill[N-1:1], 1'b0};
            default: y = x;
        endcase
    end

    assign bit_out = is_left(mode) ? x[N-1] : x[0];

    // Top bits of the fill vectors are never read; tie them off explicitly.
    assign right_fill[N-1] = 1'b0;
    assign left_fill[0]    = 1'b0;

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate engine: accepts an operand, mode and amount, then
// steps the single-bit shifter once per clock and holds the result for the consumer.
module shift_sequencer
    import alu_shift_pkg::*;
#(
    parameter int N     = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [1:0]       in_mode,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic             out_carry,
    output logic             out_zero
);

    state_t           state_reg,  state_next;
    logic [N-1:0]     work_reg,   work_next;
    logic [1:0]       mode_reg,   mode_next;
    logic [AMT_W-1:0] cnt_reg,    cnt_next;
    logic             carry_reg,  carry_next;
    logic             zero_reg,   zero_next;

    logic [N-1:0]     step_y;
    logic             step_bit;

    shift_step #(.N(N)) u_step (
        .x       (work_reg),
        .mode    (mode_reg),
        .y       (step_y),
        .bit_out (step_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            mode_reg  <= ROR;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            mode_reg  <= mode_next;
            cnt_reg   <= cnt_next;
            carry_reg <= carry_next;
            zero_reg  <= zero_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        mode_next  = mode_reg;
        cnt_next   = cnt_reg;
        carry_next = carry_reg;
        zero_next  = zero_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    work_next  = in_a;
                    mode_next  = in_mode;
                    cnt_next   = in_amt;
                    carry_next = 1'b0;
                    // A zero amount finishes immediately, so its flags must be ready now.
                    zero_next  = (in_a == '0);
                    state_next = (in_amt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Flags track every step; the values left after the last step are what the consumer sees.
                work_next  = step_y;
                carry_next = step_bit;
                zero_next  = (step_y == '0);
                cnt_next   = cnt_reg - AMT_W'(1);
                if (cnt_reg == AMT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign out_result = work_reg;
    assign out_carry  = carry_reg;
    assign out_zero   = zero_reg;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift/rotate engine for the 8-bit ALU. It accepts an operand, a shift mode and a shift amount through a valid/ready handshake. It then applies the ALU's single-bit shift/rotate operation once per clock until the requested amount is done, and holds the result until the consumer takes it. It sits directly in front of the single-bit shifter stage and extends the shift amount from 1 to anything between 0 and N-1 bits.

## Interface
- N, 8, operand width in bits
- AMT_W, 3, shift-amount width; must equal $clog2(N)
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  reset, synchronous and active-low
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- in_a  input  N  operand
- in_mode  input  2  operation select {s2,s3}: 00 rotate right, 01 rotate left, 10 logical shift right, 11 shift left
- in_amt  input  AMT_W  number of single-bit steps
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- out_result  output  N  shifted/rotated operand
- out_carry  output  1  bit moved out on the final step
- out_zero  output  1  out_result == 0

## Operation
- States: IDLE, RUN, DONE.
- in_ready = (state == IDLE), decoded combinationally from the state register. out_valid = (state == DONE).
- **IDLE.** When in_valid && in_ready at a clock edge, the block latches in_a into the work register, in_mode into the mode register and in_amt into the counter.
  - in_amt == 0: go to DONE with the result equal to in_a and carry = 0.
  - Otherwise: go to RUN.
- **RUN.** Each edge applies one step to the work register and decrements the counter.
  - When the counter goes from 1 to 0, go to DONE.
  - out_carry and out_zero are registered on that same edge.
- **Single step:**
  - ROR: {x[0], x[N-1:1]}
  - ROL: {x[N-2:0], x[N-1]}
  - SHR: {1'b0, x[N-1:1]}, zero fill. This is not arithmetic; the sign bit is not replicated.
  - SHL: {x[N-2:0], 1'b0}
- **Carry.**
  - Right modes: bit 0 of the value before the last step.
  - Left modes: bit N-1 of the value before the last step.
- **DONE.** out_result, out_carry and out_zero stay stable until out_valid && out_ready. On that edge the block goes to IDLE. There is no same-cycle re-accept.
- Input changes outside the accept edge are ignored. The mode and amount are fixed for the life of the operation.
- **Reset.** rst_n low at an edge gives:
  - state = IDLE, out_result = 0, out_carry = 0, out_zero = 0, counter = 0.
  - An in-flight operation is discarded with no output.
  - Reset has priority over every handshake.

## Timing
- Handshake at edge E0:
  - in_amt == 0: out_valid is high in the cycle after E0.
  - in_amt == k: out_valid first goes high after edge E0+k.
- Throughput: one operation every amt+2 cycles with out_ready held high (accept, k steps, drain).
- out_valid never drops without a handshake. in_ready is low from the accept edge until the drain edge.
- The block has no combinational path from inputs to outputs. in_ready depends only on state.

## Structure
- Package alu_shift_pkg holds:
  - Mode localparams: ROR=2'b00, ROL=2'b01, SHR=2'b10, SHL=2'b11. These are shared with the single-bit shifter.
  - The state encoding IDLE/RUN/DONE.
- Sub-module shift_step #(N): combinational.
  - Inputs: x, mode. Outputs: y, bit_out.
  - Instantiated once on the work register.
- Top level holds the FSM, counter, work register and flag registers.

## Test plan
- **Reset mid-RUN.** ROR, A=0x96, amt 5; assert rst_n=0 for 2 cycles after 2 steps. Required: in_ready=1, out_valid=0, out_result=0x00. A fresh request then completes normally.
- **ROR.** A=0x96 (1001_0110), amt 3. Required: out_result=0xD2, out_carry=1, out_zero=0, out_valid high after edge E0+3.
- **Shift flags.**
  - SHR, A=0x01, amt 1: out_result=0x00, out_carry=1, out_zero=1.
  - SHL, A=0x81, amt 1: out_result=0x02, out_carry=1.
  - SHR, A=0x80, amt 7: out_result=0x01 with zero fill.
- **Zero amount.** ROL, A=0x5A, amt 0. Required: out_result=0x5A, out_carry=0, out_valid in the cycle after the handshake.
- **Backpressure.** SHL, A=0x0F, amt 2; hold out_ready=0 for 5 cycles while in_valid=1 with other data. Required: out_result holds 0x3C, in_ready=0, no new accept. After out_ready=1, the block returns to IDLE and the pending request is accepted the next cycle.
- **Maximum amount.** ROL, A=0xB4, amt 7. Required: out_result=0x5A (equal to ROR by 1), out_carry=0, 7-cycle latency.
